// File: rtl/ed25519_scalar_seq_if.sv
// Request/result bundle between the scalar-multiply sequencer (master) and its environment (slave).
// Carries launch, scalar and base point in, result out, and the point-arithmetic op/result handshake.
interface ed25519_scalar_seq_if #(
  parameter int NBITS = 253,
  parameter int W     = 257
);
  logic             start;
  logic [NBITS-1:0] n;
  logic [W-1:0]     x, y, z, t;
  logic             busy;
  logic             done;
  logic [W-1:0]     x3, y3, z3, t3;
  logic             op_valid;
  logic             op_ready;
  logic             op_dbl;
  logic [4*W-1:0]   op_a;
  logic [4*W-1:0]   op_b;
  logic             res_valid;
  logic [4*W-1:0]   res;

  modport master (
    input  start, n, x, y, z, t, op_ready, res_valid, res,
    output busy, done, x3, y3, z3, t3, op_valid, op_dbl, op_a, op_b
  );

  modport slave (
    output start, n, x, y, z, t, op_ready, res_valid, res,
    input  busy, done, x3, y3, z3, t3, op_valid, op_dbl, op_a, op_b
  );
endinterface

// File: rtl/ed25519_scalar_seq.sv
// MSB-first double-and-add sequencer; one op in flight, waits on op_ready then res_valid, done pulses with result.
// ED25519_SEQ_CT_EN selects constant-time mode (no leading-zero scan, DOUBLE+ADD for every bit).
module ed25519_scalar_seq #(
  parameter int NBITS = 253,
  parameter int W     = 257
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ed25519_scalar_seq_if.master   bus
);

`ifdef ED25519_SEQ_CT_EN
  localparam bit CT_EN = 1'b1;
`else
  localparam bit CT_EN = 1'b0;
`endif

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [4*W-1:0] IDENT = {W'(0), W'(1), W'(1), W'(0)};

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [NBITS-1:0] n_q, n_d;
  logic [4*W-1:0]   r_q, r_d;
  logic [4*W-1:0]   p_q, p_d;
  logic [4*W-1:0]   out_q, out_d;
  logic             bit_set;

  assign bit_set = n_q[i_q];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    n_d     = n_q;
    r_d     = r_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = bus.n;
          p_d     = {bus.x, bus.y, bus.z, bus.t};
          i_d     = IW'(NBITS - 1);
          r_d     = IDENT;
          state_d = CT_EN ? S_DBL_REQ : S_SCAN;
        end
      end
      S_SCAN: begin
        // Leading set bit loads R with P directly, saving a double and an add.
        if (bit_set) r_d = p_q;
        if (i_q == '0) begin
          state_d = S_DONE;
        end else begin
          i_d = i_q - IW'(1);
          if (bit_set) state_d = S_DBL_REQ;
        end
      end
      S_DBL_REQ: begin
        if (bus.op_ready) state_d = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (bus.res_valid) begin
          r_d     = bus.res;
          state_d = (CT_EN || bit_set) ? S_ADD_REQ : S_NEXT;
        end
      end
      S_ADD_REQ: begin
        if (bus.op_ready) state_d = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (bus.res_valid) begin
          // Constant-time mode always adds but keeps the sum only for set bits.
          if (!CT_EN || bit_set) r_d = bus.res;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (i_q == '0) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - IW'(1);
          state_d = S_DBL_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Result register loads on entry to DONE so it is visible alongside the done pulse.
    out_d = (state_d == S_DONE) ? r_d : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      n_q     <= n_d;
      r_q     <= r_d;
      p_q     <= p_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.op_valid = (state_q == S_DBL_REQ) || (state_q == S_ADD_REQ);
  assign bus.op_dbl   = (state_q == S_DBL_REQ);
  assign bus.op_a     = r_q;
  assign bus.op_b     = p_q;
  assign bus.x3       = out_q[4*W-1:3*W];
  assign bus.y3       = out_q[3*W-1:2*W];
  assign bus.z3       = out_q[2*W-1:W];
  assign bus.t3       = out_q[W-1:0];

endmodule

// File: doc/ed25519_scalar_seq.md
# ed25519_scalar_seq

Parametrised scalar-multiplication sequencer for extended twisted-Edwards points (X:Y:Z:T). It scans an NBITS-wide scalar MSB-first and runs left-to-right double-and-add, holding the accumulator R and base P internally. Each DOUBLE/ADD is issued to an external point-arithmetic unit over a valid/ready request and result-valid return. It generalises the fixed-width ed25519 core to any scalar and coordinate width, adds a stall-tolerant operation handshake and a `busy` flag, and offers a compile-time constant-time mode.

## Interface
- `NBITS`, 253: scalar width (≥2).
- `W`, 257: coordinate width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch; sampled only in IDLE.
- `n` in NBITS: scalar, captured on accepted `start`.
- `x`,`y`,`z`,`t` in W each: base point P, captured on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse; result valid.
- `x3`,`y3`,`z3`,`t3` out W each: result R; held until the next `done`.
- `op_valid` out 1: operation request.
- `op_ready` in 1: unit accepts the request.
- `op_dbl` out 1: 1 = compute 2·A; 0 = compute A+B.
- `op_a` out 4W: operand A = R, packed {X,Y,Z,T}.
- `op_b` out 4W: operand B = P, packed {X,Y,Z,T}.
- `res_valid` in 1: result present.
- `res` in 4W: result, packed {X,Y,Z,T}.

## Operation
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE.
- IDLE: `start`=1 captures `n` and P, sets bit index i=NBITS-1, sets R to the identity (0,1,1,0), and goes to SCAN (default build) or DBL_REQ (CT build).
- SCAN (default build only), one bit per cycle:
  - n[i]=0 and i>0: decrement i and stay.
  - n[i]=0 and i=0: go to DONE with R = identity.
  - n[i]=1: set R:=P with no operation issued; if i=0 go to DONE, else decrement i and go to DBL_REQ.
- DBL_REQ: assert `op_valid`, `op_dbl`=1. On `op_ready`, go to DBL_WAIT.
- DBL_WAIT: on `res_valid`, R:=`res`. Then go to ADD_REQ if n[i]=1 (or always in CT); otherwise go to NEXT.
- ADD_REQ: assert `op_valid`, `op_dbl`=0. On `op_ready`, go to ADD_WAIT.
- ADD_WAIT: on `res_valid`, R:=`res` (CT: only if n[i]=1). Then go to NEXT.
- NEXT: if i=0 go to DONE; else decrement i and go to DBL_REQ.
- DONE: copy R to `x3..t3`, pulse `done`, return to IDLE.
- Operation counts for n with most-significant set bit at position m:
  - Default build: m doubles, plus popcount(n)−1 adds.
  - CT build: exactly NBITS doubles and NBITS adds.

## Timing
- Reset (`rst_n`=0, any time, asynchronous):
  - State goes to IDLE.
  - `busy`, `done`, `op_valid`, `op_dbl` = 0.
  - `op_a`, `op_b`, `x3..t3` = 0.
  - Internal R, P, n and i are cleared.
  - A result returned after reset is ignored.
- `start` while not in IDLE is ignored.
- `start` and `res_valid` in the same cycle in IDLE: `start` is taken and `res_valid` is ignored.
- While `op_valid`=1, `op_dbl`, `op_a` and `op_b` are stable until the `op_ready` cycle. `op_valid` drops the cycle after acceptance.
- Zero-latency unit:
  - `res_valid` is accepted only in the *_WAIT states, and no earlier than the cycle after `op_ready`.
  - `res_valid` in any other state is dropped.
- Latency, default build: 1 (capture) + (NBITS−m) SCAN cycles + Σ per-op (REQ wait + WAIT wait) + one NEXT per remaining bit + 1 (DONE).
- `done` and the new `x3..t3` appear in the same cycle. `busy` falls the cycle after.

## Configuration
- `ED25519_SEQ_CT_EN`:
  - Defined: constant-time mode. SCAN is skipped and R starts at the identity. Every bit issues DOUBLE then ADD, and the ADD result is discarded when n[i]=0. The operation count and sequence are independent of n.
  - Undefined: leading-zero SCAN runs and ADD is issued only for set bits.

## Test plan
Bench stub unit: componentwise integer arithmetic mod 2^W (dbl → 2·A, add → A+B), fixed 3-cycle latency, `op_ready` random 50%. Only X is checked.
- n=25, P.x=3, default build → `done` with `x3`=75; exactly 4 DBL and 2 ADD requests; `busy` high throughout.
- Same stimulus with `ED25519_SEQ_CT_EN` → `x3`=75; exactly NBITS DBL and NBITS ADD requests.
- n=0, default build → `done` after NBITS SCAN cycles; zero requests; `x3..t3`=(0,1,1,0).
- n=1 → `x3`=P.x with zero requests (default build).
- `rst_n` pulled low while in DBL_WAIT (n=25) → all outputs 0 immediately; the stub's late `res_valid` is ignored. A following `start` with n=2, P.x=5 gives `x3`=10.
- Second `start` pulsed while busy, plus `res_valid` pulsed in IDLE → no effect; first result unchanged.
